// File: rtl/memory_dp_param.sv
// Dual-port byte-enabled RAM with configurable width and read-during-write mode.
// After reset, a sequencer zeroes the array and holds ready low until it is done.
module memory_dp_param #(
    parameter int MEM_SIZE       = 8192,
    parameter int DATA_WIDTH     = 32,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1,
    localparam int BYTES  = DATA_WIDTH / 8,
    localparam int DEPTH  = MEM_SIZE / BYTES,
    localparam int ADDR_W = $clog2(MEM_SIZE),
    localparam int OFF_W  = $clog2(BYTES),
    localparam int IDX_W  = ADDR_W - OFF_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_W-1:0]     addr_a,
    input  logic [DATA_WIDTH-1:0] data_i_a,
    input  logic [BYTES-1:0]      data_en_a,
    input  logic                  write_en_a,
    output logic [DATA_WIDTH-1:0] data_o_a,
    input  logic [ADDR_W-1:0]     addr_b,
    input  logic [DATA_WIDTH-1:0] data_i_b,
    input  logic [BYTES-1:0]      data_en_b,
    input  logic                  write_en_b,
    output logic [DATA_WIDTH-1:0] data_o_b,
    output logic                  ready,
    output logic                  collision
);

    typedef enum logic {ST_CLEAR, ST_RUN} state_e;

    localparam state_e RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      cnt_q, cnt_d;
    logic                  ready_q, ready_d;
    logic                  coll_q, coll_d;
    logic [DATA_WIDTH-1:0] rd_a_q, rd_a_d, rd_b_q, rd_b_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [IDX_W-1:0]      idx_a, idx_b;
    logic [DATA_WIDTH-1:0] old_a, old_b, own_a, own_b, fin_a;
    logic [BYTES-1:0]      en_a, en_b;
    logic                  same, run, wr_a, wr_b;
    logic                  unused_addr;

    function automatic logic [DATA_WIDTH-1:0] merge(
        input logic [DATA_WIDTH-1:0] old,
        input logic [DATA_WIDTH-1:0] wd,
        input logic [BYTES-1:0]      en
    );
        logic [DATA_WIDTH-1:0] r;
        r = old;
        for (int k = 0; k < BYTES; k++)
            if (en[k]) r[8*k +: 8] = wd[8*k +: 8];
        return r;
    endfunction

    assign idx_a       = addr_a[ADDR_W-1:OFF_W];
    assign idx_b       = addr_b[ADDR_W-1:OFF_W];
    assign unused_addr = ^(addr_a & ADDR_W'(BYTES-1)) ^ ^(addr_b & ADDR_W'(BYTES-1));

    // ready_q tracks RUN one-for-one, and is also low while reset is held.
    assign run  = ready_q;
    assign same = (idx_a == idx_b);
    assign en_a = write_en_a ? data_en_a : '0;
    assign en_b = write_en_b ? data_en_b : '0;
    assign wr_a = run && write_en_a;
    assign wr_b = run && write_en_b && !(same && write_en_a);

    assign old_a = mem[idx_a];
    assign old_b = mem[idx_b];
    assign own_a = merge(old_a, data_i_a, en_a);
    assign own_b = merge(old_b, data_i_b, en_b);
    // Same-word dual write: start from B's merge and overlay A so A wins shared bytes.
    assign fin_a = merge((same && write_en_b) ? own_b : old_a, data_i_a, en_a);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == IDX_W'(DEPTH-1)) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
        ready_d = (state_d == ST_RUN);
        rd_a_d  = '0;
        rd_b_d  = '0;
        coll_d  = 1'b0;
        if (run) begin
            rd_a_d = (RDW_MODE != 0) ? own_a : old_a;
            rd_b_d = (RDW_MODE != 0) ? own_b : old_b;
            coll_d = write_en_a && write_en_b && same && |(data_en_a & data_en_b);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            coll_q  <= 1'b0;
            rd_a_q  <= '0;
            rd_b_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            coll_q  <= coll_d;
            rd_a_q  <= rd_a_d;
            rd_b_q  <= rd_b_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem[cnt_q] <= '0;
        end else begin
            if (wr_a) mem[idx_a] <= fin_a;
            if (wr_b) mem[idx_b] <= own_b;
        end
    end

    assign data_o_a  = rd_a_q;
    assign data_o_b  = rd_b_q;
    assign ready     = ready_q;
    assign collision = coll_q;

endmodule

// File: tb/tb_memory_dp_param.sv
// Bench for memory_dp_param: a 32-bit read-first instance against a byte-array model,
// plus a 64-bit write-first instance driven with directed vectors.
module tb_memory_dp_param;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [12:0] addr_a, addr_b;
    logic [31:0] data_i_a, data_i_b, data_o_a, data_o_b;
    logic [3:0]  data_en_a, data_en_b;
    logic        write_en_a, write_en_b, ready, collision;

    logic [11:0] addr_a64, addr_b64;
    logic [63:0] data_i_a64, data_i_b64, data_o_a64, data_o_b64;
    logic [7:0]  data_en_a64, data_en_b64;
    logic        write_en_a64, write_en_b64, ready64, collision64;

    memory_dp_param u_dut (
        .clk(clk), .rst_n(rst_n),
        .addr_a(addr_a), .data_i_a(data_i_a), .data_en_a(data_en_a),
        .write_en_a(write_en_a), .data_o_a(data_o_a),
        .addr_b(addr_b), .data_i_b(data_i_b), .data_en_b(data_en_b),
        .write_en_b(write_en_b), .data_o_b(data_o_b),
        .ready(ready), .collision(collision)
    );

    memory_dp_param #(.MEM_SIZE(4096), .DATA_WIDTH(64), .RDW_MODE(1), .CLEAR_ON_RESET(1)) u_dut64 (
        .clk(clk), .rst_n(rst_n),
        .addr_a(addr_a64), .data_i_a(data_i_a64), .data_en_a(data_en_a64),
        .write_en_a(write_en_a64), .data_o_a(data_o_a64),
        .addr_b(addr_b64), .data_i_b(data_i_b64), .data_en_b(data_en_b64),
        .write_en_b(write_en_b64), .data_o_b(data_o_b64),
        .ready(ready64), .collision(collision64)
    );

    int n_chk = 0;
    int n_err = 0;
    logic [7:0] ref_mem [8192];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // One access on the 32-bit instance, checked against the byte-array model.
    task automatic step(input logic [12:0] aa, input logic [31:0] da, input logic [3:0] ea, input logic wa,
                        input logic [12:0] ab, input logic [31:0] db, input logic [3:0] eb, input logic wb);
        logic [31:0] exp_a, exp_b;
        logic        exp_c;
        int          ba, bb;
        ba = int'(aa) & ~3;
        bb = int'(ab) & ~3;
        for (int k = 0; k < 4; k++) begin
            exp_a[8*k +: 8] = ref_mem[ba+k];
            exp_b[8*k +: 8] = ref_mem[bb+k];
        end
        exp_c = wa && wb && (ba == bb) && ((ea & eb) != 4'h0);
        if (wb) for (int k = 0; k < 4; k++) if (eb[k]) ref_mem[bb+k] = db[8*k +: 8];
        if (wa) for (int k = 0; k < 4; k++) if (ea[k]) ref_mem[ba+k] = da[8*k +: 8];
        addr_a = aa; data_i_a = da; data_en_a = ea; write_en_a = wa;
        addr_b = ab; data_i_b = db; data_en_b = eb; write_en_b = wb;
        write_en_a64 = 1'b0; write_en_b64 = 1'b0;
        cycle();
        chk("rd_a", 64'(data_o_a), 64'(exp_a));
        chk("rd_b", 64'(data_o_b), 64'(exp_b));
        chk("coll", 64'(collision), 64'(exp_c));
    endtask

    task automatic step64(input logic [11:0] aa, input logic [63:0] da, input logic [7:0] ea, input logic wa,
                          input logic [11:0] ab, input logic [63:0] db, input logic [7:0] eb, input logic wb);
        addr_a64 = aa; data_i_a64 = da; data_en_a64 = ea; write_en_a64 = wa;
        addr_b64 = ab; data_i_b64 = db; data_en_b64 = eb; write_en_b64 = wb;
        write_en_a = 1'b0; write_en_b = 1'b0;
        cycle();
    endtask

    task automatic wait_ready(input string tag, input int want, input int want64);
        int n, n64;
        n = 0;
        n64 = -1;
        while (!ready && n < 3000) begin
            cycle();
            n++;
            if (ready64 && n64 < 0) n64 = n;
            if (n == 5) chk({tag, "_rd0"}, 64'(data_o_a), 64'h0);
            if (n == 6) chk({tag, "_coll0"}, 64'(collision), 64'h0);
        end
        chk({tag, "_len"}, 64'(n), 64'(want));
        if (want64 > 0) chk({tag, "_len64"}, 64'(n64), 64'(want64));
        for (int i = 0; i < 8192; i++) ref_mem[i] = 8'h00;
    endtask

    initial begin
        addr_a = 13'h1FFC; data_i_a = 32'hFFFF_FFFF; data_en_a = 4'hF; write_en_a = 1'b1;
        addr_b = 13'h0;    data_i_b = 32'hA5A5_A5A5; data_en_b = 4'hF; write_en_b = 1'b1;
        addr_a64 = '0; data_i_a64 = '0; data_en_a64 = '0; write_en_a64 = 1'b0;
        addr_b64 = '0; data_i_b64 = '0; data_en_b64 = '0; write_en_b64 = 1'b0;
        repeat (3) cycle();
        chk("rst_ready", 64'(ready), 64'h0);
        chk("rst_rd_a", 64'(data_o_a), 64'h0);
        chk("rst_coll", 64'(collision), 64'h0);
        chk("rst_ready64", 64'(ready64), 64'h0);

        // Writes are held on during the whole clear and must be discarded.
        rst_n = 1'b1;
        wait_ready("clr", 2048, 512);
        step(13'h1FFC, 32'h0, 4'h0, 1'b0, 13'h0, 32'h0, 4'h0, 1'b0);
        chk("clr_top_word", 64'(data_o_a), 64'h0);

        step(13'h10, 32'hDEAD_BEEF, 4'hF, 1'b1, 13'h0, 32'h0, 4'h0, 1'b0);
        step(13'h10, 32'h00AA_0000, 4'h4, 1'b1, 13'h0, 32'h0, 4'h0, 1'b0);
        step(13'h12, 32'h0, 4'h0, 1'b0, 13'h13, 32'h0, 4'h0, 1'b0);
        chk("be_merge", 64'(data_o_a), 64'hDEAA_BEEF);

        step(13'h20, 32'h1111_1111, 4'h3, 1'b1, 13'h20, 32'h2222_2222, 4'h6, 1'b1);
        chk("coll_pulse", 64'(collision), 64'h1);
        step(13'h20, 32'h0, 4'h0, 1'b0, 13'h22, 32'h0, 4'h0, 1'b0);
        chk("coll_word", 64'(data_o_a), 64'h0022_1111);
        chk("coll_drop", 64'(collision), 64'h0);
        step(13'h30, 32'h1, 4'h1, 1'b1, 13'h30, 32'h2, 4'h2, 1'b1);
        chk("nocoll_disjoint", 64'(collision), 64'h0);

        step(13'h40, 32'h1234_5678, 4'hF, 1'b1, 13'h0, 32'h0, 4'h0, 1'b0);
        step(13'h40, 32'hCAFE_F00D, 4'hF, 1'b1, 13'h40, 32'h0, 4'h0, 1'b0);
        chk("rdw0_a", 64'(data_o_a), 64'h1234_5678);
        chk("rdw0_b", 64'(data_o_b), 64'h1234_5678);

        step64(12'h8, 64'h0123_4567_89AB_CDEF, 8'hF0, 1'b1, 12'h0, 64'h0, 8'h00, 1'b0);
        step64(12'hF, 64'h0, 8'h00, 1'b0, 12'h8, 64'h0, 8'h00, 1'b0);
        chk("w64_a", data_o_a64, 64'h0123_4567_0000_0000);
        chk("w64_b", data_o_b64, 64'h0123_4567_0000_0000);
        step64(12'h40, 64'h1122_3344_5566_7788, 8'hFF, 1'b1, 12'h0, 64'h0, 8'h00, 1'b0);
        step64(12'h40, 64'hCAFE_F00D_CAFE_F00D, 8'h0F, 1'b1, 12'h47, 64'h0, 8'h00, 1'b0);
        chk("rdw1_a", data_o_a64, 64'h1122_3344_CAFE_F00D);
        chk("rdw1_b", data_o_b64, 64'h1122_3344_5566_7788);
        step64(12'h80, {8{8'hAA}}, 8'h01, 1'b1, 12'h80, {8{8'hBB}}, 8'h03, 1'b1);
        chk("dual64_a", data_o_a64, 64'h0000_0000_0000_00AA);
        chk("dual64_b", data_o_b64, 64'h0000_0000_0000_BBBB);
        chk("dual64_coll", 64'(collision64), 64'h1);
        step64(12'h80, 64'h0, 8'h00, 1'b0, 12'h8, 64'h0, 8'h00, 1'b0);
        chk("dual64_word", data_o_a64, 64'h0000_0000_0000_BBAA);
        chk("dual64_coll_drop", 64'(collision64), 64'h0);

        for (int i = 0; i < 400; i++) begin
            logic [12:0] ra, rb;
            ra = ($urandom_range(0, 1) == 0) ? 13'($urandom_range(0, 63)) : 13'($urandom);
            rb = ($urandom_range(0, 1) == 0) ? 13'($urandom_range(0, 63)) : 13'($urandom);
            step(ra, $urandom, 4'($urandom), ($urandom_range(0, 3) != 0),
                 rb, $urandom, 4'($urandom), ($urandom_range(0, 3) != 0));
        end

        // Asynchronous drop while both instances are running with nonzero read data.
        step(13'h100, 32'h5A5A_5A5A, 4'hF, 1'b1, 13'h0, 32'h0, 4'h0, 1'b0);
        step(13'h100, 32'h0, 4'h0, 1'b0, 13'h0, 32'h0, 4'h0, 1'b0);
        chk("pre_rst_rd", 64'(data_o_a), 64'h5A5A_5A5A);
        step64(12'h8, 64'h0, 8'h00, 1'b0, 12'h0, 64'h0, 8'h00, 1'b0);
        chk("pre_rst_rd64", data_o_a64, 64'h0123_4567_0000_0000);
        rst_n = 1'b0;
        #1;
        chk("arst_ready", 64'(ready), 64'h0);
        chk("arst_rd_a", 64'(data_o_a), 64'h0);
        chk("arst_ready64", 64'(ready64), 64'h0);
        chk("arst_rd64", data_o_a64, 64'h0);
        cycle();
        rst_n = 1'b1;
        write_en_a = 1'b1;
        repeat (1000) cycle();
        chk("mid_clr_ready", 64'(ready), 64'h0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(ready), 64'h0);
        chk("mid_rst_rd", 64'(data_o_a), 64'h0);
        cycle();
        rst_n = 1'b1;
        wait_ready("clr2", 2048, 512);
        step(13'h100, 32'h0, 4'h0, 1'b0, 13'h20, 32'h0, 4'h0, 1'b0);
        chk("clr2_word", 64'(data_o_a), 64'h0);
        for (int i = 0; i < 40; i++)
            step(13'($urandom_range(0, 255)), $urandom, 4'($urandom), 1'b1,
                 13'($urandom_range(0, 255)), $urandom, 4'($urandom), ($urandom_range(0, 1) == 1));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/memory_dp_param.md
Name: memory_dp_param

Overview:
- Parametrised dual-port, byte-enabled main memory for instructions and data. Successor to the fixed 32-bit dual-port RAM.
- Adds the following over that block:
  - configurable data width;
  - selectable read-during-write mode;
  - defined same-word write-collision arbitration with a collision flag;
  - a post-reset clear sequencer that zeroes the array and gates both ports with a ready signal.
- Sits between the core's fetch port (A) and load/store port (B).

Parameters:
- MEM_SIZE, 8192, total bytes; power of 2.
- DATA_WIDTH, 32, port data width in bits; power of 2, at least 8.
- RDW_MODE, 0, same-port read-during-write: 0 = read-first (old data), 1 = write-first (new merged data).
- CLEAR_ON_RESET, 1, 1 = zero the whole array after reset; 0 = skip the clear and go straight to RUN.
- Derived constants:
  - BYTES = DATA_WIDTH/8
  - DEPTH = MEM_SIZE/BYTES
  - ADDR_W = clog2(MEM_SIZE)
  - OFF_W = clog2(BYTES)

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- addr_a  in  ADDR_W  port A byte address; low OFF_W bits ignored.
- data_i_a  in  DATA_WIDTH  port A write data.
- data_en_a  in  BYTES  port A byte enables, relative to the word.
- write_en_a  in  1  port A write strobe.
- data_o_a  out  DATA_WIDTH  port A registered read data.
- addr_b, data_i_b, data_en_b, write_en_b, data_o_b: identical set for port B.
- ready  out  1  high when the array accepts accesses (RUN state).
- collision  out  1  registered one-cycle pulse on a same-word, overlapping-byte dual write.

Behaviour:
- Word index = addr >> OFF_W. Byte k of the word is bits [8k+7:8k] and is controlled by data_en[k].
- Reset values (asynchronous, while rst_n = 0): data_o_a = 0, data_o_b = 0, ready = 0, collision = 0, clear counter = 0. Array contents are not reset asynchronously.
- FSM states:
  - CLEAR:
    - Entered on reset release if CLEAR_ON_RESET = 1.
    - Writes 0 to word[cnt] each cycle and increments cnt.
    - At cnt = DEPTH-1 the write occurs and the FSM moves to RUN on the next edge.
    - Takes exactly DEPTH cycles. ready = 0 throughout.
  - RUN:
    - Entered directly on reset release if CLEAR_ON_RESET = 0.
    - ready = 1. Normal access. Stays in RUN until reset.
- rst_n asserted mid-CLEAR or mid-RUN: FSM returns to reset values immediately. On release, CLEAR restarts from word 0. Partially cleared contents are not trusted.
- During CLEAR:
  - write_en_a/b are ignored (no array write).
  - data_o_a/b are held at 0.
  - collision stays 0.
- Read (RUN): data_o updates every cycle with a 1-cycle latency: value of the addressed word as of the rising edge, subject to the read-during-write rules below. No read-enable; reads are always performed.
- Write (RUN, write_en = 1): only bytes with data_en[k] = 1 are updated. write_en = 1 with data_en = 0 is a no-op write; the read still occurs.
- Same-port read-during-write:
  - RDW_MODE = 0: data_o = pre-write word.
  - RDW_MODE = 1: data_o = word after the byte merge.
- Cross-port read of a word the other port writes in the same cycle: always returns the pre-write word, in either mode.
- Dual write, same word index:
  - Bytes enabled on only one port take that port's data.
  - Bytes enabled on both ports take port A's data (port A wins).
  - collision = 1 on the next cycle iff (data_en_a & data_en_b) != 0; otherwise 0.
- Dual write to different words: both complete; collision = 0.
- RDW_MODE = 1 with a same-word dual write: each port's data_o shows its own merge only, because cross-port reads see pre-write data.

Test Plan:
- Clear sequence:
  - Stimulus: DEPTH = 2048; release rst_n; drive write_en_a = 1 throughout CLEAR.
  - Response: ready rises exactly 2048 cycles after release; the write is discarded; reading any word, e.g. word 0x7FF (byte address 0x1FFC), returns 0.
- Byte-enable write:
  - Stimulus: write 0xDEADBEEF to addr 0x10 with data_en = 0xF; then write 0x00AA0000 with data_en = 0x4; then read addr 0x12.
  - Response: data_o one cycle later = 0xDEAABEEF; the low 2 address bits are ignored.
- Collision:
  - Stimulus: same cycle, A writes 0x11111111 with data_en = 0x3 to addr 0x20; B writes 0x22222222 with data_en = 0x6 to addr 0x20.
  - Response: word = 0x00221111; collision pulses high for exactly 1 cycle.
- Read-during-write:
  - Stimulus: word 0x40 holds 0x12345678; port A writes 0xCAFEF00D there.
  - Response:
    - RDW_MODE = 0: data_o_a = 0x12345678.
    - RDW_MODE = 1: data_o_a = 0xCAFEF00D.
    - Port B reading 0x40 in the same cycle gets 0x12345678 in both modes.
- Reset mid-clear:
  - Stimulus: assert rst_n = 0 at clear cycle 1000; release.
  - Response: ready and data_o drop to 0 immediately; ready returns exactly DEPTH cycles after the second release.
- Width generalisation:
  - Stimulus: DATA_WIDTH = 64, MEM_SIZE = 4096; write 0x0123456789ABCDEF with data_en = 0xF0 to addr 0x8.
  - Response: readback of addr 0xF = 0x0123456700000000 after clear.
